// File: rtl/acc_window_pkg.sv
// Shared types and arithmetic helpers for the acc_window multi-lane accumulator.
package acc_window_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Widest lane the saturating adder supports; lanes sign-extend into this.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] sum;
    } sat_res_t;

    // Adds two width-bit signed values (sign-extended to SAT_MAX_W) with one
    // guard bit, then clamps the result into the signed width-bit range.
    function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                         input logic [SAT_MAX_W-1:0] b,
                                         input int unsigned          width);
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sat_res_t                  r;
        s  = signed'({a[SAT_MAX_W-1], a}) + signed'({b[SAT_MAX_W-1], b});
        hi = ((SAT_MAX_W+1)'(1) << (width - 1)) - (SAT_MAX_W+1)'(1);
        lo = ~hi;
        r.sat = 1'b0;
        r.sum = s[SAT_MAX_W-1:0];
        if (s > hi) begin
            r.sat = 1'b1;
            r.sum = hi[SAT_MAX_W-1:0];
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.sum = lo[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_window_if.sv
// Upstream beat / downstream result handshake bundle for acc_window.
interface acc_window_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic                   i_valid;
    logic                   i_ready;
    logic                   i_acc;
    logic [CNT_W-1:0]       i_len;
    logic [LANES*WIDTH-1:0] i_psum;
    logic [LANES*WIDTH-1:0] i_data;
    logic                   o_valid;
    logic                   o_ready;
    logic [LANES*WIDTH-1:0] o_data;
    logic [LANES-1:0]       o_sat;

    modport slave (
        input  i_valid, i_acc, i_len, i_psum, i_data, o_ready,
        output i_ready, o_valid, o_data, o_sat
    );

    modport master (
        output i_valid, i_acc, i_len, i_psum, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/acc_window_lane.sv
// One accumulator lane: sum register plus wrapping or saturating adder.
// Saturation is enabled by defining ACC_WINDOW_SAT_EN.
module acc_window_lane
    import acc_window_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic             first,
    input  logic             seed_sel,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum_nxt;

    // The first beat of a window restarts from the seed instead of the old sum.
    assign base = first ? (seed_sel ? seed : '0) : sum;

`ifdef ACC_WINDOW_SAT_EN
    sat_res_t res;
    logic     unused_res;

    assign res        = sat_add({{(SAT_MAX_W-WIDTH){base[WIDTH-1]}}, base},
                                {{(SAT_MAX_W-WIDTH){data[WIDTH-1]}}, data},
                                WIDTH);
    assign sum_nxt    = res.sum[WIDTH-1:0];
    assign unused_res = ^res.sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (clr) begin
            sat <= 1'b0;
        end else if (step) begin
            sat <= res.sat | (sat & ~first);
        end
    end
`else
    assign sum_nxt = base + data;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (step) begin
            sum <= sum_nxt;
        end
    end

endmodule

// File: rtl/acc_window.sv
// Multi-lane windowed signed accumulator with valid/ready on both sides.
// Define ACC_WINDOW_SAT_EN for saturating adds and sticky per-lane o_sat.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a window
//   ACCUM | window open, collecting beats until cnt reaches len
//   HOLD  | result presented on o_data, waiting for o_ready
module acc_window
    import acc_window_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    acc_window_if.slave  bus
);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       len_in;
    logic                   accept;
    logic                   first;
    logic                   last_beat;
    logic [LANES*WIDTH-1:0] sum_all;
    logic [LANES-1:0]       sat_all;

    assign len_in    = (bus.i_len == '0) ? CNT_W'(1) : bus.i_len;
    assign last_beat = (state_q == ACCUM) ? ((cnt_q + CNT_W'(1)) == len_q)
                                          : (len_in == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = last_beat ? HOLD : ACCUM;
                end
                ACCUM: begin
                    if (accept && last_beat) state_d = HOLD;
                end
                HOLD: begin
                    // A beat taken while the result drains opens the next window.
                    if (accept)           state_d = last_beat ? HOLD : ACCUM;
                    else if (bus.o_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_valid = (state_q == HOLD);
        bus.i_ready = en & ~clr & ((state_q != HOLD) | bus.o_ready);
        accept      = bus.i_valid & bus.i_ready;
        first       = accept & (state_q != ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (accept) begin
            if (first) begin
                cnt_q <= CNT_W'(1);
                len_q <= len_in;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        acc_window_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .step     (accept),
            .first    (first),
            .seed_sel (bus.i_acc),
            .seed     (bus.i_psum[k*WIDTH +: WIDTH]),
            .data     (bus.i_data[k*WIDTH +: WIDTH]),
            .sum      (sum_all[k*WIDTH +: WIDTH]),
            .sat      (sat_all[k])
        );
    end

    assign bus.o_data = sum_all;
    assign bus.o_sat  = sat_all;

endmodule

// File: tb/tb_acc_window.sv
// Randomized and directed bench for acc_window against a window-level model.
module tb_acc_window;
    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clr;

    acc_window_if #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    acc_window #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Window-level reference: running sums per lane, open-window and pending-result flags.
    longint m_acc[LANES];
    bit     m_sat[LANES];
    bit     m_in_win;
    bit     m_hold;
    int     m_beats;
    int     m_len;
    int     windows_done = 0;
    bit     last_fire;

    function automatic longint m_add(input longint a, input longint b, output bit s);
        longint r;
        r = a + b;
        s = 1'b0;
`ifdef ACC_WINDOW_SAT_EN
        if (r > MAXV) begin r = MAXV; s = 1'b1; end
        else if (r < MINV) begin r = MINV; s = 1'b1; end
`else
        r = longint'(int'(r));
`endif
        return r;
    endfunction

    function automatic longint lane_of(input logic [LANES*WIDTH-1:0] v, input int k);
        logic signed [WIDTH-1:0] x;
        x = v[k*WIDTH +: WIDTH];
        return longint'(x);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < LANES; k++) begin
            m_acc[k] = 0;
            m_sat[k] = 1'b0;
        end
        m_in_win = 1'b0;
        m_hold   = 1'b0;
        m_beats  = 0;
        m_len    = 0;
    endtask

    task automatic model_eval();
        bit exp_rdy;
        bit s;
        exp_rdy   = en && !clr && (!m_hold || bus.o_ready);
        last_fire = 1'b0;
        chk("i_ready", bus.i_ready, exp_rdy);
        chk("o_valid", bus.o_valid, m_hold);
        if (m_hold) begin
            for (int k = 0; k < LANES; k++) begin
                chk($sformatf("o_data%0d", k), bus.o_data[k*WIDTH +: WIDTH], m_acc[k][WIDTH-1:0]);
                chk($sformatf("o_sat%0d", k), bus.o_sat[k], m_sat[k]);
            end
        end
        if (clr) begin
            m_reset();
        end else if (en) begin
            last_fire = bus.i_valid && exp_rdy;
            if (m_hold && bus.o_ready) begin
                m_hold = 1'b0;
                windows_done++;
            end
            if (last_fire) begin
                if (!m_in_win) begin
                    for (int k = 0; k < LANES; k++) begin
                        m_acc[k] = m_add(bus.i_acc ? lane_of(bus.i_psum, k) : 0,
                                         lane_of(bus.i_data, k), s);
                        m_sat[k] = s;
                    end
                    m_len   = (bus.i_len == 0) ? 1 : int'(bus.i_len);
                    m_beats = 1;
                    if (m_len == 1) m_hold = 1'b1;
                    else            m_in_win = 1'b1;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        m_acc[k] = m_add(m_acc[k], lane_of(bus.i_data, k), s);
                        m_sat[k] = m_sat[k] | s;
                    end
                    m_beats++;
                    if (m_beats == m_len) begin
                        m_in_win = 1'b0;
                        m_hold   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) model_eval();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_val(input bit big);
        if (big) return WIDTH'($urandom());
        return WIDTH'($urandom_range(0, 2000)) - WIDTH'(1000);
    endfunction

    task automatic set_lanes(input longint p0, input longint d0, input bit big);
        bus.i_psum[0 +: WIDTH] = p0[WIDTH-1:0];
        bus.i_data[0 +: WIDTH] = d0[WIDTH-1:0];
        for (int k = 1; k < LANES; k++) begin
            bus.i_psum[k*WIDTH +: WIDTH] = rnd_val(big);
            bus.i_data[k*WIDTH +: WIDTH] = rnd_val(big);
        end
    endtask

    task automatic beat(input bit acc, input int len, input longint p0, input longint d0);
        bus.i_acc   = acc;
        bus.i_len   = CNT_W'(len);
        set_lanes(p0, d0, 1'b0);
        bus.i_valid = 1'b1;
        last_fire   = 1'b0;
        for (int n = 0; n < 20 && !last_fire; n++) tick();
        chk("beat_accept", last_fire, 1'b1);
        bus.i_valid = 1'b0;
    endtask

    task automatic consume();
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        bus.i_valid = 1'b0; bus.i_acc = 1'b0; bus.i_len = '0;
        bus.i_psum = '0; bus.i_data = '0; bus.o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_data", |bus.o_data, 1'b0);
        chk("rst_sat", |bus.o_sat, 1'b0);
        rst_n = 1'b1;
        tick();

        // basic three-beat window
        beat(0, 3, 0, 5); beat(0, 3, 0, -2);
        beat(0, 3, 0, 10);
        chk("t1_valid", bus.o_valid, 1'b1);
        chk("t1_sum", bus.o_data[WIDTH-1:0], 32'd13);
        consume();

        // seeded window
        beat(1, 2, 100, 1); beat(1, 2, 100, 2);
        chk("t2_sum", bus.o_data[WIDTH-1:0], 32'd103);
        consume();

        // len 0 acts as a single beat
        beat(0, 0, 0, 7);
        chk("t3_valid", bus.o_valid, 1'b1);
        chk("t3_sum", bus.o_data[WIDTH-1:0], 32'd7);
        consume();

        // backpressure, then drain and restart in the same cycle
        beat(0, 2, 0, 3); beat(0, 2, 0, 4);
        bus.i_valid = 1'b1; bus.i_acc = 1'b0; bus.i_len = 8'd2; set_lanes(0, 9, 1'b0);
        repeat (4) tick();
        chk("t4_held", bus.o_data[WIDTH-1:0], 32'd7);
        bus.o_ready = 1'b1;
        tick();
        chk("t4_nobubble", last_fire, 1'b1);
        bus.o_ready = 1'b0; bus.i_valid = 1'b0;
        beat(0, 2, 0, 1);
        chk("t4_sum", bus.o_data[WIDTH-1:0], 32'd10);
        consume();

        // clear mid-window with a beat present
        beat(0, 4, 0, 1); beat(0, 4, 0, 2);
        clr = 1'b1; bus.i_valid = 1'b1;
        tick();
        clr = 1'b0; bus.i_valid = 1'b0;
        chk("t5_clr_valid", bus.o_valid, 1'b0);
        chk("t5_clr_data", |bus.o_data, 1'b0);
        beat(0, 2, 0, 4); beat(0, 2, 0, 5);
        chk("t5_after_clr", bus.o_data[WIDTH-1:0], 32'd9);
        consume();

        // enable stall mid-window
        beat(0, 3, 0, 1);
        en = 1'b0; bus.i_valid = 1'b1;
        repeat (3) tick();
        en = 1'b1; bus.i_valid = 1'b0;
        beat(0, 3, 0, 2); beat(0, 3, 0, 3);
        chk("t5_stall_sum", bus.o_data[WIDTH-1:0], 32'd6);
        consume();

        // overflow: saturate or wrap depending on build
        beat(1, 1, 64'sh7FFFFFF0, 64'sh20);
`ifdef ACC_WINDOW_SAT_EN
        chk("t6_pos", bus.o_data[WIDTH-1:0], 32'h7FFFFFFF);
        chk("t6_pos_sat", bus.o_sat[0], 1'b1);
`else
        chk("t6_pos", bus.o_data[WIDTH-1:0], 32'h80000010);
        chk("t6_pos_sat", bus.o_sat[0], 1'b0);
`endif
        consume();
        beat(1, 2, -64'sh7FFFFFF0, -64'sh20); beat(1, 2, 0, 5);
`ifdef ACC_WINDOW_SAT_EN
        chk("t6_neg", bus.o_data[WIDTH-1:0], 32'h80000005);
        chk("t6_neg_sat", bus.o_sat[0], 1'b1);
`else
        chk("t6_neg", bus.o_data[WIDTH-1:0], 32'h7FFFFFF5);
        chk("t6_neg_sat", bus.o_sat[0], 1'b0);
`endif
        consume();
        beat(0, 1, 0, 1);
        chk("t6_sat_cleared", bus.o_sat[0], 1'b0);
        chk("t6_next", bus.o_data[WIDTH-1:0], 32'd1);
        consume();

        // async reset while holding a result
        beat(0, 1, 0, 42);
        chk("t7_pre", bus.o_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_valid", bus.o_valid, 1'b0);
        chk("t7_data", |bus.o_data, 1'b0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            en          = ($urandom_range(0, 9) != 0);
            clr         = ($urandom_range(0, 49) == 0);
            bus.i_valid = ($urandom_range(0, 9) < 7);
            bus.o_ready = ($urandom_range(0, 9) < 6);
            bus.i_acc   = $urandom_range(0, 1);
            bus.i_len   = CNT_W'($urandom_range(0, 5));
            set_lanes(longint'(signed'(rnd_val(c[2]))), longint'(signed'(rnd_val(c[3]))), c[2]);
            tick();
        end
        chk("windows_progress", windows_done > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
